// File: rtl/datapath_sequencer.sv
// Instruction sequencer for the A/B/O register file, ALU and shift register datapath.
// Accepts one opcode/operand per handshake and drives Moore strobes until a done pulse.
module datapath_sequencer #(
  parameter int INPUT_WIDTH  = 4,
  parameter int OPCODE_WIDTH = 4,
  parameter int COUNT_WIDTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [OPCODE_WIDTH-1:0] instr_opcode,
  input  logic [INPUT_WIDTH-1:0]  instr_operand,
  output logic [INPUT_WIDTH-1:0]  data_out,
  output logic                    lda,
  output logic                    ldb,
  output logic                    ldo,
  output logic [2:0]              alu_op,
  output logic                    shift_load,
  output logic [1:0]              shift_state,
  input  logic                    shift_flag,
  output logic                    busy,
  output logic                    done,
  output logic                    err_illegal,
  output logic                    underflow
);

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    ALU_WB,
    SHIFT,
    DONE
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDB = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(7);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDS = OPCODE_WIDTH'(8);
  localparam logic [OPCODE_WIDTH-1:0] OP_SHL = OPCODE_WIDTH'(9);
  localparam logic [OPCODE_WIDTH-1:0] OP_SHR = OPCODE_WIDTH'(10);

  state_t                  state;
  state_t                  next_state;
  logic [OPCODE_WIDTH-1:0] opcode_q;
  logic [INPUT_WIDTH-1:0]  operand_q;
  logic [COUNT_WIDTH-1:0]  count;
  logic                    accept;
  logic                    is_alu;
  logic                    is_shift;
  logic                    is_illegal;

  assign accept     = instr_valid && (state == IDLE);
  assign is_alu     = (opcode_q >= OP_ADD) && (opcode_q <= OP_XOR);
  assign is_shift   = (opcode_q == OP_SHL) || (opcode_q == OP_SHR);
  assign is_illegal = (opcode_q > OP_SHR);
  assign data_out   = operand_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A zero shift count skips SHIFT entirely so no shift_state activity is seen.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (is_alu) begin
          next_state = ALU_WB;
        end else if (is_shift && (operand_q != '0)) begin
          next_state = SHIFT;
        end else begin
          next_state = DONE;
        end
      end
      ALU_WB: next_state = DONE;
      SHIFT: begin
        if (count == COUNT_WIDTH'(1)) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The final right shift reports its flag one cycle late, hence DONE is also sampled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode_q  <= '0;
      operand_q <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      if (accept) begin
        opcode_q  <= instr_opcode;
        operand_q <= instr_operand;
        underflow <= 1'b0;
      end else if ((opcode_q == OP_SHR) && ((state == SHIFT) || (state == DONE)) && shift_flag) begin
        underflow <= 1'b1;
      end
      if ((state == EXEC) && is_shift) begin
        count <= COUNT_WIDTH'(operand_q);
      end else if (state == SHIFT) begin
        count <= count - COUNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    instr_ready = 1'b0;
    lda         = 1'b0;
    ldb         = 1'b0;
    ldo         = 1'b0;
    shift_load  = 1'b0;
    alu_op      = 3'd0;
    shift_state = 2'b00;
    done        = 1'b0;
    err_illegal = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: instr_ready = 1'b1;
      EXEC: begin
        lda        = (opcode_q == OP_LDA);
        ldb        = (opcode_q == OP_LDB);
        shift_load = (opcode_q == OP_LDS);
        if (is_alu) begin
          alu_op = 3'(opcode_q - OP_ADD);
        end
      end
      ALU_WB: begin
        ldo    = 1'b1;
        alu_op = 3'(opcode_q - OP_ADD);
      end
      SHIFT: shift_state = (opcode_q == OP_SHL) ? 2'b10 : 2'b01;
      DONE: begin
        done        = 1'b1;
        err_illegal = is_illegal;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Instruction-level controller for the CPU datapath: A/B/O register file, ALU and 8-bit shift register. It accepts one opcode/operand pair per valid/ready handshake. It then drives the register load enables, ALU op select and shift-state lines for the required number of cycles, and signals completion with a done pulse. It sits between the SPI instruction front end and the datapath.

Parameters:
INPUT_WIDTH, 4, width of operand and of A/B register data
OPCODE_WIDTH, 4, width of the instruction opcode
COUNT_WIDTH, 4, width of the shift-count down-counter (equals INPUT_WIDTH)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
instr_valid  in  1  instruction present on instr_opcode/instr_operand
instr_ready  out  1  sequencer can accept an instruction
instr_opcode  in  OPCODE_WIDTH  opcode
instr_operand  in  INPUT_WIDTH  immediate data or shift count
data_out  out  INPUT_WIDTH  data to A/B register inputs (latched operand)
lda  out  1  load enable, A register
ldb  out  1  load enable, B register
ldo  out  1  load enable, O register (ALU result)
alu_op  out  3  ALU function select: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
shift_load  out  1  load enable, shift register
shift_state  out  2  2'b10 LSH, 2'b01 RSH, 2'b00 hold
shift_flag  in  1  underflow flag from shift register
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
err_illegal  out  1  one-cycle pulse, coincident with done, for an undefined opcode
underflow  out  1  sticky RSH underflow indication

Behaviour:
- States: IDLE, EXEC, ALU_WB, SHIFT, DONE. All strobes are Moore outputs decoded from the state and the latched opcode; no combinational path from instr_* to strobes.
- Reset: the async assert forces IDLE at once.
  - Zero at once: lda, ldb, ldo, shift_load, done, err_illegal, underflow; shift_state = 2'b00, alu_op = 0, data_out = 0, count = 0.
  - instr_ready = 1 after reset releases.
  - A reset mid-instruction abandons that instruction; no done is produced.
- IDLE:
  - instr_ready = 1.
  - On the rising edge with instr_valid & instr_ready: latch opcode and operand, clear underflow, go to EXEC.
  - instr_ready = 0 in every other state, and instr_valid is ignored there.
- EXEC (1 cycle), by opcode:
  - 0 NOP: no strobes, go to DONE.
  - 1 LDA: lda = 1, data_out = operand, go to DONE.
  - 2 LDB: ldb = 1, data_out = operand, go to DONE.
  - 3-7 ALU ops: alu_op = opcode-3, go to ALU_WB. alu_op is held stable from EXEC through ALU_WB.
  - 8 LDS: shift_load = 1, data_out = operand, go to DONE.
  - 9 SHL / 10 SHR: count <= operand. If operand == 0, go straight to DONE with no shift cycles; otherwise go to SHIFT.
  - 11-15: illegal; go to DONE with err_illegal asserted there.
- ALU_WB (1 cycle): ldo = 1, go to DONE.
- SHIFT:
  - shift_state = 2'b10 (SHL) or 2'b01 (SHR) every cycle; count decrements each cycle.
  - Leave for DONE after the cycle where count == 1, so shift_state is non-zero for exactly operand cycles.
- underflow:
  - During an SHR, underflow is set if shift_flag == 1 is sampled in SHIFT or DONE. DONE is included because the final shift's flag arrives one cycle late.
  - Once set, it holds until reset or the next accepted instruction.
- DONE (1 cycle): done = 1, then go to IDLE.
- Latency from the accept edge:
  - NOP/LDA/LDB/LDS/illegal: done in the 2nd cycle after accept.
  - ALU: done in the 3rd cycle.
  - SHL/SHR with count n: done in cycle n+2.
- Throughput: minimum 3 cycles per instruction, because DONE always returns to IDLE before the next accept.
- Never more than one of lda/ldb/ldo/shift_load is active, and never together with a non-zero shift_state.

Test Plan:
- Reset, then LDA operand 4'hA: lda = 1 for exactly 1 cycle with data_out = 4'hA; done 1 cycle later; instr_ready = 1 in the cycle after done.
- SUB (opcode 4) after LDA 5 and LDB 3: alu_op = 1 for 2 cycles, then ldo = 1 for 1 cycle during the second; done 1 cycle after ldo.
- LDS 4'b0011, then SHR with count 3: shift_state = 2'b01 for exactly 3 consecutive cycles. A model shift_flag asserts after the first shift, so underflow = 1 sticky until the next accept.
- SHL with count 0: no shift_state activity; done 2 cycles after accept. Opcode 4'hF: err_illegal and done assert together; no load strobes.
- instr_valid held high continuously: accepts occur only in IDLE; opcode changes in non-IDLE cycles are ignored, and a burst of 4 NOPs completes in 12 cycles.
- Async reset asserted mid-SHIFT (count = 5, after 2 shifts): shift_state = 0 and busy = 0 immediately, without waiting for a clock edge; no done pulse; instr_ready = 1 after release.
